spi_master_param: RTL and testbench
===================================

SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 Parameter DATA_W, default 8: transfer word width in bits, range 4..32.
REQ-002 Parameter DIV, default 2: SCLK half-period in CLK50 cycles, range 1..255.
REQ-003 Parameter NCS, default 1: number of chip-select lines, range 1..8.
REQ-004 CLK50  in  1  system clock; all logic SHALL be on its rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 W_STB  in  1  transfer request; qualified only in IDLE.
REQ-007 W_DATA  in  DATA_W  word to transmit, MSB first.
REQ-008 CS_SEL  in  clog2(NCS) (min 1)  chip-select index for the transfer.
REQ-009 CPOL  in  1  SCLK idle level for the transfer.
REQ-010 CPHA  in  1  0: sample on leading edge; 1: sample on trailing edge.
REQ-011 W_ACK  out  1  one-cycle pulse: request accepted.
REQ-012 BUSY  out  1  high from acceptance until the cycle before R_STB.
REQ-013 R_STB  out  1  one-cycle pulse: R_DATA valid.
REQ-014 R_DATA  out  DATA_W  received word; held until the next R_STB.
REQ-015 SCLK  out  1  serial clock, registered, glitch-free.
REQ-016 MOSI  out  1  serial data out, registered.
REQ-017 MISO  in  1  serial data in; SHALL pass through a 2-FF synchroniser before sampling.
REQ-018 CS_N  out  NCS  active-low chip selects, registered.

Function
REQ-019 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD.
REQ-020 IDLE: W_STB=1 sampled at edge k SHALL latch W_DATA, CS_SEL, CPOL and CPHA, pulse W_ACK in cycle k+1, and enter SETUP.
REQ-021 W_STB outside IDLE SHALL be ignored: no W_ACK, no queuing.
REQ-022 SETUP: CS_N[CS_SEL] low from k+1; SCLK stays at CPOL; lasts DIV cycles.
REQ-023 CPHA=0: MOSI SHALL carry the data MSB from k+1.
REQ-024 SHIFT: 2*DATA_W SCLK edges, each DIV cycles apart; first edge at the start of SHIFT is leading, edges alternate leading/trailing.
REQ-025 The sampling edge (leading if CPHA=0, trailing if CPHA=1) SHALL shift the synchronised MISO into the receive register LSB.
REQ-026 The other edge SHALL advance MOSI to the next bit; with CPHA=1 the first leading edge SHALL drive the MSB.
REQ-027 No MOSI advance after the final sampling edge; SCLK SHALL end SHIFT at CPOL.
REQ-028 HOLD: DIV cycles with CS_N still asserted.
REQ-029 After HOLD, in one cycle: CS_N all high, R_STB=1, R_DATA updated, BUSY=0, state IDLE.
REQ-030 Latency from W_STB edge k to R_STB: k+1+DIV*(2*DATA_W+2) cycles.
REQ-031 A new W_STB MAY be accepted in the R_STB cycle; CS_N SHALL then deassert for at least that one cycle.
REQ-032 MOSI SHALL be 1 whenever CS_N is all high.
REQ-033 CS_SEL >= NCS SHALL run the transfer with no CS_N line asserted.
REQ-034 The bit counter SHALL be wide enough for 2*DATA_W without wrap.
REQ-035 The divider counter SHALL reload at DIV-1 and wrap cleanly.

Reset
REQ-036 RST=1 SHALL force, immediately and mid-transfer: IDLE, CS_N all 1, SCLK=0, MOSI=1, W_ACK=0, R_STB=0, BUSY=0, R_DATA=0, counters 0.
REQ-037 A transfer interrupted by RST SHALL NOT produce R_STB.
REQ-038 From the first request after reset, SCLK SHALL follow the latched CPOL.

Verification
REQ-039 DATA_W=8, DIV=2, mode 0, W_DATA=0xA5, MISO looped to MOSI -> R_DATA=0xA5; R_STB at k+37; 8 SCLK rising edges; CS_N[0] low k+1..k+36.
REQ-040 Modes 1, 2, 3, W_DATA=0x3C, slave model returns 0xC3 -> R_DATA=0xC3 in each mode; SCLK idle level equals CPOL.
REQ-041 NCS=4, CS_SEL=2 -> only CS_N[2] low; a W_STB during BUSY -> no W_ACK and R_DATA unchanged.
REQ-042 RST pulse at k+10 of a transfer -> CS_N=all 1, MOSI=1 immediately; no R_STB; the next transfer returns correct data.
REQ-043 DATA_W=16, DIV=1, W_DATA=0x8001, loopback, back-to-back W_STB in the R_STB cycle -> two R_STB pulses 35 cycles apart, both 0x8001.

Source files
------------

// File: rtl/spi_master_param.sv
// ---------------------------------------------------------------------------
// spi_master_param
//   Parameterised SPI master. It accepts one word per request and shifts it
//   out MSB first. At the same time it shifts a word in from MISO. The
//   transfer runs IDLE -> SETUP -> SHIFT -> HOLD -> IDLE. Each of SETUP and
//   HOLD lasts DIV cycles. SHIFT makes 2*DATA_W SCLK edges, DIV cycles apart.
//   CPOL, CPHA and the chip-select index are latched per transfer.
//
// Parameters
//   DATA_W  word width (4..32)
//   DIV     SCLK half-period in CLK50 cycles (1..255)
//   NCS     number of chip-select lines (1..8)
//
// Ports
//   CLK50, RST        clock; asynchronous active-high reset
//   W_STB / W_ACK     request (taken only in IDLE) / one-cycle accept pulse
//   W_DATA, CS_SEL    word to send and chip-select index, latched on accept
//   CPOL, CPHA        SPI mode for the transfer, latched on accept
//   BUSY              high from accept until the cycle before R_STB
//   R_STB / R_DATA    one-cycle completion pulse / received word (held)
//   SCLK, MOSI, CS_N  registered SPI outputs
//   MISO              serial input, passed through a 2-FF synchroniser
//   dbg_state         current FSM state (IDLE=0, SETUP=1, SHIFT=2, HOLD=3)
//
// Handshake: W_STB is a level that is sampled on each rising edge while the
//   FSM is IDLE. A sampled 1 is a request. W_ACK pulses for exactly one cycle
//   on the cycle after the request is taken. A W_STB outside IDLE is dropped
//   and is not queued. R_STB pulses once per finished transfer, in the same
//   cycle that R_DATA takes its new value.
// ---------------------------------------------------------------------------
module spi_master_param #(
    parameter int  DATA_W = 8,
    parameter int  DIV    = 2,
    parameter int  NCS    = 1,
    localparam int CSW    = (NCS > 1) ? $clog2(NCS) : 1
) (
    input  logic              CLK50,
    input  logic              RST,
    input  logic              W_STB,
    input  logic [DATA_W-1:0] W_DATA,
    input  logic [CSW-1:0]    CS_SEL,
    input  logic              CPOL,
    input  logic              CPHA,
    output logic              W_ACK,
    output logic              BUSY,
    output logic              R_STB,
    output logic [DATA_W-1:0] R_DATA,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic [NCS-1:0]    CS_N,
    output logic [1:0]        dbg_state
);

    localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
    // The edge counter must hold 2*DATA_W itself: that value is the
    // "all edges done" marker.
    localparam int EDGW = $clog2(2 * DATA_W + 1);

    localparam logic [DIVW-1:0] DIV_LAST   = DIVW'(DIV - 1);
    localparam logic [EDGW-1:0] EDGE_END   = EDGW'(2 * DATA_W);
    localparam logic [EDGW-1:0] EDGE_FINAL = EDGW'(2 * DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DIVW-1:0]   div_q, div_d;
    logic [EDGW-1:0]   edge_q, edge_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic [NCS-1:0]    cs_n_q, cs_n_d;
    logic              w_ack_q, w_ack_d;
    logic              r_stb_q, r_stb_d;
    logic              busy_q, busy_d;
    logic              miso_s1_q, miso_s1_d;
    logic              miso_s2_q, miso_s2_d;
    logic              samp1_q, samp1_d;
    logic              samp2_q, samp2_d;

    logic              tick;
    logic              do_edge;
    logic [EDGW-1:0]   edge_idx;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        edge_d    = edge_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        r_data_d  = r_data_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        w_ack_d   = 1'b0;
        r_stb_d   = 1'b0;
        busy_d    = busy_q;
        miso_s1_d = MISO;
        miso_s2_d = miso_s1_q;
        samp1_d   = 1'b0;
        samp2_d   = samp1_q;
        do_edge   = 1'b0;
        edge_idx  = edge_q;

        tick = (div_q == DIV_LAST);

        // The synchroniser delays MISO by two cycles. So a sampling edge sets
        // a strobe, and the strobe goes down a matching two-stage pipe. Bit
        // capture then lines up with the MISO level present at the sampling
        // edge, even at DIV=1.
        if (samp2_q) begin
            rx_d = {rx_q[DATA_W-2:0], miso_s2_q};
        end

        case (state_q)
            IDLE: begin
                div_d  = '0;
                edge_d = '0;
                if (W_STB) begin
                    state_d = SETUP;
                    w_ack_d = 1'b1;
                    busy_d  = 1'b1;
                    cpol_d  = CPOL;
                    cpha_d  = CPHA;
                    sclk_d  = CPOL;
                    cs_n_d  = '1;
                    for (int i = 0; i < NCS; i++) begin
                        if (32'(CS_SEL) == i) begin
                            cs_n_d[i] = 1'b0;
                        end
                    end
                    if (CPHA) begin
                        // The MSB goes out on the first leading edge.
                        mosi_d = 1'b1;
                        tx_d   = W_DATA;
                    end else begin
                        mosi_d = W_DATA[DATA_W-1];
                        tx_d   = {W_DATA[DATA_W-2:0], 1'b0};
                    end
                end
            end

            SETUP: begin
                div_d = tick ? '0 : div_q + DIVW'(1);
                if (tick) begin
                    state_d  = SHIFT;
                    do_edge  = 1'b1;
                    edge_idx = '0;
                    edge_d   = EDGW'(1);
                end
            end

            SHIFT: begin
                div_d = tick ? '0 : div_q + DIVW'(1);
                if (tick) begin
                    if (edge_q == EDGE_END) begin
                        state_d = HOLD;
                    end else begin
                        do_edge = 1'b1;
                        edge_d  = edge_q + EDGW'(1);
                    end
                end
            end

            HOLD: begin
                div_d = tick ? '0 : div_q + DIVW'(1);
                if (tick) begin
                    state_d  = IDLE;
                    cs_n_d   = '1;
                    mosi_d   = 1'b1;
                    r_stb_d  = 1'b1;
                    busy_d   = 1'b0;
                    edge_d   = '0;
                    // rx_d already holds any capture that falls in this cycle.
                    r_data_d = rx_d;
                end
            end

            default: state_d = IDLE;
        endcase

        // Even edge indices are leading edges and odd ones are trailing.
        // With CPHA=0 we sample on leading edges; with CPHA=1 on trailing.
        // On the other edge MOSI moves to the next bit, except after the
        // final sampling edge.
        if (do_edge) begin
            sclk_d = ~sclk_q;
            if (edge_idx[0] == cpha_q) begin
                samp1_d = 1'b1;
            end else if (edge_idx != EDGE_FINAL) begin
                mosi_d = tx_q[DATA_W-1];
                tx_d   = {tx_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge CLK50 or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            div_q     <= '0;
            edge_q    <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            r_data_q  <= '0;
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b1;
            cs_n_q    <= '1;
            w_ack_q   <= 1'b0;
            r_stb_q   <= 1'b0;
            busy_q    <= 1'b0;
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
            samp1_q   <= 1'b0;
            samp2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            r_data_q  <= r_data_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            w_ack_q   <= w_ack_d;
            r_stb_q   <= r_stb_d;
            busy_q    <= busy_d;
            miso_s1_q <= miso_s1_d;
            miso_s2_q <= miso_s2_d;
            samp1_q   <= samp1_d;
            samp2_q   <= samp2_d;
        end
    end

    assign W_ACK     = w_ack_q;
    assign BUSY      = busy_q;
    assign R_STB     = r_stb_q;
    assign R_DATA    = r_data_q;
    assign SCLK      = sclk_q;
    assign MOSI      = mosi_q;
    assign CS_N      = cs_n_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_master_param.sv
// ---------------------------------------------------------------------------
// tb_spi_master_param
//   Two instances of the master are driven from one clock:
//     dut_a: DATA_W=8,  DIV=2, NCS=4. Used for the mode, chip-select, stray
//            request and reset scenarios. MISO comes either from a loopback
//            of MOSI or from a behavioural SPI slave.
//     dut_b: DATA_W=16, DIV=1, NCS=1. Used for back-to-back transfers and an
//            out-of-range chip select. MISO comes from a loopback of MOSI or
//            from a constant.
//   Expected words come from the slave or loopback rules. They go through a
//   scoreboard queue. Expected timing is computed from 1+DIV*(2*DATA_W+2).
// ---------------------------------------------------------------------------
module tb_spi_master_param;

    localparam int AW    = 8;
    localparam int ADIV  = 2;
    localparam int ANCS  = 4;
    localparam int BW    = 16;
    localparam int BDIV  = 1;
    localparam int BNCS  = 1;
    localparam int LAT_A = 1 + ADIV * (2 * AW + 2);
    localparam int LAT_B = 1 + BDIV * (2 * BW + 2);
    localparam int SB_W  = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [SB_W-1:0] exp_q[$];

    // ---------------- dut_a ----------------
    logic            a_w_stb = 1'b0;
    logic [AW-1:0]   a_w_data = '0;
    logic [1:0]      a_cs_sel = '0;
    logic            a_cpol = 1'b0;
    logic            a_cpha = 1'b0;
    logic            a_w_ack, a_busy, a_r_stb, a_sclk, a_mosi, a_miso;
    logic [AW-1:0]   a_r_data;
    logic [ANCS-1:0] a_cs_n;
    logic [1:0]      a_dbg;
    logic            a_loop = 1'b1;

    // ---------------- dut_b ----------------
    logic            b_w_stb = 1'b0;
    logic [BW-1:0]   b_w_data = '0;
    logic [0:0]      b_cs_sel = '0;
    logic            b_cpol = 1'b0;
    logic            b_cpha = 1'b0;
    logic            b_w_ack, b_busy, b_r_stb, b_sclk, b_mosi, b_miso;
    logic [BW-1:0]   b_r_data;
    logic [BNCS-1:0] b_cs_n;
    logic [1:0]      b_dbg;
    logic            b_loop = 1'b1;
    logic            b_miso_val = 1'b1;

    // ---------------- behavioural slave for dut_a ----------------
    logic          cur_cpol = 1'b0;
    logic          cur_cpha = 1'b0;
    logic [AW-1:0] slv_word = '0;
    logic          slv_miso = 1'b0;
    logic          slv_prev_sclk = 1'b0;
    int            slv_idx = 0;

    assign a_miso = a_loop ? a_mosi : slv_miso;
    assign b_miso = b_loop ? b_mosi : b_miso_val;

    spi_master_param #(.DATA_W(AW), .DIV(ADIV), .NCS(ANCS)) dut_a (
        .CLK50(clk), .RST(rst), .W_STB(a_w_stb), .W_DATA(a_w_data),
        .CS_SEL(a_cs_sel), .CPOL(a_cpol), .CPHA(a_cpha), .W_ACK(a_w_ack),
        .BUSY(a_busy), .R_STB(a_r_stb), .R_DATA(a_r_data), .SCLK(a_sclk),
        .MOSI(a_mosi), .MISO(a_miso), .CS_N(a_cs_n), .dbg_state(a_dbg)
    );

    spi_master_param #(.DATA_W(BW), .DIV(BDIV), .NCS(BNCS)) dut_b (
        .CLK50(clk), .RST(rst), .W_STB(b_w_stb), .W_DATA(b_w_data),
        .CS_SEL(b_cs_sel), .CPOL(b_cpol), .CPHA(b_cpha), .W_ACK(b_w_ack),
        .BUSY(b_busy), .R_STB(b_r_stb), .R_DATA(b_r_data), .SCLK(b_sclk),
        .MOSI(b_mosi), .MISO(b_miso), .CS_N(b_cs_n), .dbg_state(b_dbg)
    );

    // The slave presents its MSB when the transfer starts if CPHA=0. After
    // that it shifts out the next bit on each trailing edge (CPHA=0) or on
    // each leading edge (CPHA=1).
    always @(negedge clk) begin
        if (a_w_ack) begin
            slv_idx = AW - 1;
            if (!cur_cpha) begin
                slv_miso = slv_word[AW-1];
                slv_idx  = AW - 2;
            end
        end else if (a_busy && (a_sclk !== slv_prev_sclk)) begin
            if ((a_sclk != cur_cpol) == cur_cpha) begin
                slv_miso = (slv_idx >= 0) ? slv_word[slv_idx] : 1'b0;
                slv_idx  = slv_idx - 1;
            end
        end
        slv_prev_sclk = a_sclk;
    end

    // ---------------- driver + checks: one transfer on dut_a ----------------
    task automatic run_xfer_a(input logic [AW-1:0] data, input logic [1:0] sel,
                              input logic cpol, input logic cpha, input logic loop,
                              input logic [AW-1:0] sword, input logic stray,
                              input string name);
        logic [AW-1:0]   exp_data;
        logic [AW-1:0]   prev_rdata;
        logic [AW-1:0]   end_rdata;
        logic [ANCS-1:0] exp_cs;
        logic [ANCS+2:0] end_state;
        logic [SB_W-1:0] sb;
        logic            prev_sclk;
        logic            first_mosi;
        int lat, acks, rises, cs_bad, busy_bad, sclk_bad, rdata_bad, extra;
        exp_data = loop ? data : sword;
        exp_q.push_back(SB_W'(exp_data));
        exp_cs = ~(ANCS'(1) << sel);
        prev_rdata = a_r_data;
        lat = -1; acks = 0; rises = 0; cs_bad = 0; busy_bad = 0;
        sclk_bad = 0; rdata_bad = 0; extra = 0;
        end_state = '0; end_rdata = '0; prev_sclk = 1'b0; first_mosi = 1'b0;

        cur_cpol = cpol; cur_cpha = cpha; a_loop = loop; slv_word = sword;
        a_w_data = data; a_cs_sel = sel; a_cpol = cpol; a_cpha = cpha;
        a_w_stb = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= LAT_A + 4 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                a_w_stb = 1'b0;
                first_mosi = a_mosi;
            end
            if (a_w_ack) acks++;
            if (c > 1 && a_sclk && !prev_sclk) rises++;
            prev_sclk = a_sclk;
            if (a_r_stb) begin
                lat = c;
                end_state = {a_cs_n, a_busy, a_mosi, a_sclk};
                end_rdata = a_r_data;
            end else begin
                if (a_cs_n !== exp_cs) cs_bad++;
                if (a_busy !== 1'b1) busy_bad++;
                if (a_r_data !== prev_rdata) rdata_bad++;
                if (c <= ADIV && a_sclk !== cpol) sclk_bad++;
            end
            if (stray && c == 15) begin
                a_w_data = ~data;
                a_w_stb  = 1'b1;
            end
            if (stray && c == 16) a_w_stb = 1'b0;
        end

        n_checks++;
        if (lat !== LAT_A) begin
            n_errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, LAT_A);
        end
        n_checks++;
        if (acks !== 1) begin
            n_errors++;
            $display("FAIL %s w_ack count: got %0d expected 1", name, acks);
        end
        n_checks++;
        if (rises !== AW) begin
            n_errors++;
            $display("FAIL %s sclk rising edges: got %0d expected %0d", name, rises, AW);
        end
        n_checks++;
        if (cs_bad !== 0) begin
            n_errors++;
            $display("FAIL %s cs_n during transfer: %0d bad cycles, expected pattern %b", name, cs_bad, exp_cs);
        end
        n_checks++;
        if (busy_bad !== 0) begin
            n_errors++;
            $display("FAIL %s busy during transfer: %0d low cycles expected 0", name, busy_bad);
        end
        n_checks++;
        if (sclk_bad !== 0) begin
            n_errors++;
            $display("FAIL %s sclk idle in setup: %0d bad cycles expected 0 (cpol %0d)", name, sclk_bad, cpol);
        end
        n_checks++;
        if (rdata_bad !== 0) begin
            n_errors++;
            $display("FAIL %s r_data held: %0d changed cycles expected 0", name, rdata_bad);
        end
        if (!cpha) begin
            n_checks++;
            if (first_mosi !== data[AW-1]) begin
                n_errors++;
                $display("FAIL %s mosi msb in setup: got %b expected %b", name, first_mosi, data[AW-1]);
            end
        end
        n_checks++;
        if (end_state !== {{ANCS{1'b1}}, 1'b0, 1'b1, cpol}) begin
            n_errors++;
            $display("FAIL %s end state {cs_n,busy,mosi,sclk}: got %b expected %b", name, end_state, {{ANCS{1'b1}}, 1'b0, 1'b1, cpol});
        end
        sb = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_checks++;
        if (SB_W'(end_rdata) !== sb) begin
            n_errors++;
            $display("FAIL %s r_data: got %h expected %h", name, end_rdata, sb);
        end
        if (stray) begin
            for (int c = 0; c < LAT_A + 3; c++) begin
                @(negedge clk);
                if (a_r_stb || a_w_ack) extra++;
            end
            n_checks++;
            if (extra !== 0) begin
                n_errors++;
                $display("FAIL %s stray request: got %0d extra ack/stb expected 0", name, extra);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [8:0] a_ctl;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        a_ctl = {a_cs_n, a_sclk, a_mosi, a_w_ack, a_r_stb, a_busy};
        n_checks++;
        if (a_ctl !== 9'b1111_0_1_0_0_0 || a_dbg !== 2'd0) begin
            n_errors++;
            $display("FAIL reset a ctl: got %b st %0d expected 111101000 st 0", a_ctl, a_dbg);
        end
        n_checks++;
        if (a_r_data !== '0) begin
            n_errors++;
            $display("FAIL reset a r_data: got %h expected 0", a_r_data);
        end
        n_checks++;
        if ({b_cs_n, b_sclk, b_mosi, b_w_ack, b_r_stb, b_busy} !== 6'b1_0_1_0_0_0 || b_r_data !== '0) begin
            n_errors++;
            $display("FAIL reset b: got %b data %h expected 101000 data 0",
                     {b_cs_n, b_sclk, b_mosi, b_w_ack, b_r_stb, b_busy}, b_r_data);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        a_ctl = {a_cs_n, a_sclk, a_mosi, a_w_ack, a_r_stb, a_busy};
        n_checks++;
        if (a_ctl !== 9'b1111_0_1_0_0_0) begin
            n_errors++;
            $display("FAIL idle after reset a ctl: got %b expected 111101000", a_ctl);
        end
    endtask

    task automatic test_mode0_loopback();
        run_xfer_a(8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, "mode0_loop_a5");
    endtask

    task automatic test_modes();
        run_xfer_a(8'h3C, 2'd0, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, "mode1_slave");
        run_xfer_a(8'h3C, 2'd0, 1'b1, 1'b0, 1'b0, 8'hC3, 1'b0, "mode2_slave");
        run_xfer_a(8'h3C, 2'd0, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, "mode3_slave");
    endtask

    task automatic test_cs_select();
        run_xfer_a(AW'($urandom), 2'd2, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, "cs2_stray");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_xfer_a(AW'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       AW'($urandom), 1'b0, $sformatf("random_%0d", i));
        end
    endtask

    task automatic test_reset_mid_transfer();
        int stb_seen;
        stb_seen = 0;
        a_loop = 1'b1;
        a_w_data = AW'($urandom); a_cs_sel = 2'd1; a_cpol = 1'b1; a_cpha = 1'b0;
        a_w_stb = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) a_w_stb = 1'b0;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({a_cs_n, a_mosi, a_sclk, a_busy, a_w_ack, a_r_stb} !== 9'b1111_1_0_0_0_0 || a_dbg !== 2'd0) begin
            n_errors++;
            $display("FAIL mid reset outputs: got %b st %0d expected 111110000 st 0",
                     {a_cs_n, a_mosi, a_sclk, a_busy, a_w_ack, a_r_stb}, a_dbg);
        end
        n_checks++;
        if (a_r_data !== '0) begin
            n_errors++;
            $display("FAIL mid reset r_data: got %h expected 0", a_r_data);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < LAT_A + 5; c++) begin
            @(negedge clk);
            if (a_r_stb) stb_seen++;
        end
        n_checks++;
        if (stb_seen !== 0) begin
            n_errors++;
            $display("FAIL mid reset r_stb: got %0d pulses expected 0", stb_seen);
        end
        run_xfer_a(AW'($urandom), 2'd3, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, "after_reset");
    endtask

    task automatic run_b2b(input logic [BW-1:0] d1, input logic [BW-1:0] d2,
                           input logic cpol, input logic cpha, input string name);
        int              stb_c[2];
        logic [BW-1:0]   got[2];
        logic [1:0]      gap_state;
        logic            ack2;
        logic [SB_W-1:0] sb;
        int              n;
        n = 0; stb_c[0] = -1; stb_c[1] = -1; got[0] = '0; got[1] = '0;
        gap_state = '0; ack2 = 1'b0;
        exp_q.push_back(SB_W'(d1));
        exp_q.push_back(SB_W'(d2));
        b_loop = 1'b1; b_cs_sel = 1'b0; b_cpol = cpol; b_cpha = cpha;
        b_w_data = d1;
        b_w_stb = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 2 * LAT_B + 6 && n < 2; c++) begin
            @(negedge clk);
            if (c == 1) b_w_stb = 1'b0;
            if (n == 1 && c == stb_c[0] + 1) begin
                ack2 = b_w_ack;
                b_w_stb = 1'b0;
            end
            if (b_r_stb) begin
                stb_c[n] = c;
                got[n] = b_r_data;
                if (n == 0) begin
                    gap_state = {b_cs_n[0], b_mosi};
                    b_w_data = d2;
                    b_w_stb = 1'b1;
                end
                n++;
            end
        end
        b_w_stb = 1'b0;
        n_checks++;
        if (stb_c[0] !== LAT_B) begin
            n_errors++;
            $display("FAIL %s first latency: got %0d expected %0d", name, stb_c[0], LAT_B);
        end
        n_checks++;
        if (stb_c[1] - stb_c[0] !== LAT_B) begin
            n_errors++;
            $display("FAIL %s r_stb spacing: got %0d expected %0d", name, stb_c[1] - stb_c[0], LAT_B);
        end
        n_checks++;
        if (gap_state !== 2'b11) begin
            n_errors++;
            $display("FAIL %s {cs_n,mosi} in r_stb cycle: got %b expected 11", name, gap_state);
        end
        n_checks++;
        if (ack2 !== 1'b1) begin
            n_errors++;
            $display("FAIL %s second w_ack: got %b expected 1", name, ack2);
        end
        for (int i = 0; i < 2; i++) begin
            sb = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            n_checks++;
            if (SB_W'(got[i]) !== sb) begin
                n_errors++;
                $display("FAIL %s r_data %0d: got %h expected %h", name, i, got[i], sb);
            end
        end
    endtask

    task automatic test_back_to_back();
        run_b2b(16'h8001, 16'h8001, 1'b0, 1'b0, "b2b_8001");
        run_b2b(BW'($urandom), BW'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), "b2b_random");
    endtask

    task automatic test_cs_out_of_range();
        int lat, cs_bad;
        lat = -1; cs_bad = 0;
        b_loop = 1'b0; b_miso_val = 1'b1;
        b_cs_sel = 1'b1; b_cpol = 1'b0; b_cpha = 1'b1;
        b_w_data = BW'($urandom);
        b_w_stb = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= LAT_B + 4 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) b_w_stb = 1'b0;
            if (b_cs_n !== 1'b1) cs_bad++;
            if (b_r_stb) lat = c;
        end
        n_checks++;
        if (lat !== LAT_B) begin
            n_errors++;
            $display("FAIL cs_oor latency: got %0d expected %0d", lat, LAT_B);
        end
        n_checks++;
        if (cs_bad !== 0) begin
            n_errors++;
            $display("FAIL cs_oor cs_n asserted: %0d cycles expected 0", cs_bad);
        end
        n_checks++;
        if (b_r_data !== {BW{1'b1}}) begin
            n_errors++;
            $display("FAIL cs_oor r_data: got %h expected ffff", b_r_data);
        end
        b_loop = 1'b1;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_mode0_loopback();
        test_modes();
        test_cs_select();
        test_random();
        test_reset_mid_transfer();
        test_back_to_back();
        test_cs_out_of_range();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
